// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Brief    : Parametrised UART transmitter with baud divider and one-deep hold.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 TXstart,
    input  logic [DATA_BITS-1:0] TX_data_in,
    output logic                 TX_out,
    output logic                 TXbusy,
    output logic                 TXready,
    output logic                 TXdone
);

    localparam int                 c_DIV_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic               c_PAR_EN    = (PARITY_EN != 0);
    localparam logic               c_PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [c_DIV_W-1:0]   r_div;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [DATA_BITS-1:0] r_hold_data;
    logic                 r_hold_par;
    logic                 r_hold_full;
    logic                 r_tx;

    logic w_accept;
    logic w_bit_end;
    logic w_frame_end;
    logic w_in_par;

    assign w_accept    = TXstart & ~r_hold_full;
    assign w_bit_end   = (r_div == c_DIV_LAST);
    assign w_frame_end = (r_state == S_STOP) & w_bit_end & (r_bit_idx == c_STOP_LAST);
    assign w_in_par    = (^TX_data_in) ^ c_PAR_ODD;

    assign TX_out  = r_tx;
    assign TXbusy  = (r_state != S_IDLE);
    assign TXready = ~r_hold_full;
    assign TXdone  = w_frame_end;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_hold_data <= '0;
            r_hold_par  <= 1'b0;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            // Every state entry lands on a bit boundary, so this also restarts the divider.
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_accept && (r_state != S_IDLE) && !w_frame_end) begin
                r_hold_data <= TX_data_in;
                r_hold_par  <= w_in_par;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= TX_data_in;
                        r_par   <= w_in_par;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_DATA_LAST) begin
                            r_bit_idx <= '0;
                            if (c_PAR_EN) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= S_STOP;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_frame_end) begin
                        // Held word (or a same-cycle request) chains into the next frame with no idle gap.
                        if (r_hold_full) begin
                            r_shift     <= r_hold_data;
                            r_par       <= r_hold_par;
                            r_hold_full <= 1'b0;
                            r_state     <= S_START;
                            r_tx        <= 1'b0;
                        end else if (w_accept) begin
                            r_shift <= TX_data_in;
                            r_par   <= w_in_par;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else if (w_bit_end) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that succeeds the fixed 8-bit TRANSMITTER/TXFSM/PISO/parity_gen chain. It adds an integrated baud divider and configurable data width, parity mode and stop-bit count. A one-deep holding register allows back-to-back frames with no idle gap. It sits between the host-side byte source and the serial line pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
PARITY_EN, 1, 1 = parity bit inserted after the data bits, 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  asynchronous active-low reset.
TXstart  input  1  request/valid; a word is accepted on a rising edge where TXstart=1 and TXready=1.
TX_data_in  input  DATA_BITS  word to transmit; sampled only on acceptance.
TX_out  output  1  serial line, registered; idle level is 1.
TXbusy  output  1  high while a frame is on the line.
TXready  output  1  high when the holding register is empty, i.e. a word can be accepted.
TXdone  output  1  one-cycle pulse on the final clock of each frame's last stop bit.

Behaviour:
- Reset (async assert, sync release): TX_out=1, TXbusy=0, TXready=1, TXdone=0, FSM=IDLE. Divider, bit index and shifter are cleared and the holding register is emptied. Reset mid-frame aborts the frame: TX_out returns to 1 immediately and any held word is discarded.
- Frame format, LSB first: start bit (0), DATA_BITS data bits, optional parity bit, STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT clocks.
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) clocks.
- Parity is computed from the word at acceptance time: even parity = XOR of the data bits; odd parity = its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT clocks.
  - DATA -> PARITY (if PARITY_EN) or STOP after DATA_BITS bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> START or IDLE after STOP_BITS bit periods.
- Divider: counts 0..CLKS_PER_BIT-1 and restarts at 0 on every state entry. A bit-index counter tracks data bits and stop bits.
- Latency: acceptance at edge k while in IDLE -> TX_out=0 and TXbusy=1 from edge k+1.
- Acceptance while IDLE: the word loads straight into the shifter and TXready stays 1.
- Acceptance while busy (hold empty): the word is captured into the holding register and TXready=0 from the next edge.
- TXstart while TXready=0 is ignored: no state change, and the held word is not overwritten.
- End of frame (last clock of last stop bit): TXdone=1 for that one cycle.
  - If the hold is full: the held word moves to the shifter, START begins on the next edge with no idle clock, TXbusy stays 1, and TXready returns to 1 on the same edge.
  - Otherwise: go to IDLE and TXbusy=0 on the next edge.
- Simultaneous TXstart=1 with the end of frame and hold empty: the word is accepted and goes directly to START with no gap, equivalent to the hold-full path.
- TX_data_in changes after acceptance have no effect on the frame in flight or on the held word.

Test Plan:
1. DATA_BITS=8, CLKS_PER_BIT=4, even parity, STOP_BITS=1. Send 0xA5 from IDLE -> TX_out per 4-clock bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 (44 clocks). TXdone pulses at clock 44; TXbusy drops on the next edge.
2. Same config with PARITY_ODD=1, send 0x07 -> parity bit 0 (three ones). With PARITY_ODD=0 -> parity bit 1.
3. Back-to-back: send 0x55 and, 10 clocks later, 0x0F -> TXready=0 until the first frame ends. The second start bit begins on the clock immediately after the first TXdone, with no idle clock and TXbusy continuously 1.
4. Third TXstart (0xFF) while the hold is full -> ignored; only 0x55 and 0x0F appear on the line.
5. DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, CLKS_PER_BIT=8, send 0x41 -> 10-bit frame (80 clocks): 0, 1,0,0,0,0,0,1, 1,1.
6. Assert reset_n=0 mid-DATA with a word held -> TX_out=1 asynchronously and TXbusy=0, TXready=1. After release the line stays idle until a new TXstart arrives.
